// File: rtl/hamming_scrub_ctrl.sv
// hamming_scrub_ctrl: background SECDED scrubber for a hamming-protected bank.
// Walks every address in the idle slots of the shared bank port and reads each
// codeword. It logs single and double errors, and it writes corrected words
// back. Functional traffic always wins the port.
// Optional build macro HAM_SCRUB_DED_HALT_EN: after a DED, park in HALT until
// scrub enable is seen low.
module hamming_scrub_ctrl #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_BITS  = $clog2(DATA_BITS) + 1,
  parameter int unsigned ENCODED_WORD = DATA_BITS + PARITY_BITS,
  parameter int unsigned CW_W         = ENCODED_WORD + 1,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned ADDR_W       = $clog2(DEPTH),
  parameter int unsigned INTV_W       = 16,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_scrub_en,
  input  logic [INTV_W-1:0]    i_interval,
  input  logic                 i_func_busy,
  input  logic                 i_func_we,
  input  logic [ADDR_W-1:0]    i_func_addr,
  output logic                 o_mem_req,
  output logic                 o_mem_we,
  output logic [ADDR_W-1:0]    o_mem_addr,
  output logic [CW_W-1:0]      o_mem_wdata,
  input  logic [CW_W-1:0]      i_mem_rdata,
  output logic [CW_W-1:0]      o_dec_word,
  input  logic                 i_dec_sec,
  input  logic                 i_dec_ded,
  input  logic [DATA_BITS-1:0] i_dec_data,
  output logic [DATA_BITS-1:0] o_enc_data,
  input  logic [CW_W-1:0]      i_enc_word,
  output logic                 o_busy,
  output logic [CNT_W-1:0]     o_sec_cnt,
  output logic [CNT_W-1:0]     o_ded_cnt,
  output logic                 o_ded_irq,
  output logic [ADDR_W-1:0]    o_ded_addr,
  output logic                 o_pass_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE, WAIT, READ, CHECK, DECIDE, WRITE, NEXT, HALT
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [INTV_W-1:0]  intv_q, intv_d;
  logic [CW_W-1:0]    word_q, word_d;
  logic [CW_W-1:0]    wb_q, wb_d;
  logic [CNT_W-1:0]   sec_q, sec_d;
  logic [CNT_W-1:0]   ded_q, ded_d;
  logic [ADDR_W-1:0]  ded_addr_q, ded_addr_d;
  logic               ded_irq_q, ded_irq_d;
  logic               pass_q, pass_d;
  logic               abort_q, abort_d;
  logic               mem_req, mem_we;
  logic [DATA_BITS-1:0] enc_data;
  logic               func_hit;
`ifdef HAM_SCRUB_DED_HALT_EN
  logic               ded_seen_q, ded_seen_d;
`endif

  // Functional write landing on the word currently being scrubbed
  assign func_hit = i_func_busy & i_func_we & (i_func_addr == addr_q);

  // State and datapath registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      intv_q     <= '0;
      word_q     <= '0;
      wb_q       <= '0;
      sec_q      <= '0;
      ded_q      <= '0;
      ded_addr_q <= '0;
      ded_irq_q  <= 1'b0;
      pass_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      intv_q     <= intv_d;
      word_q     <= word_d;
      wb_q       <= wb_d;
      sec_q      <= sec_d;
      ded_q      <= ded_d;
      ded_addr_q <= ded_addr_d;
      ded_irq_q  <= ded_irq_d;
      pass_q     <= pass_d;
      abort_q    <= abort_d;
    end
  end

`ifdef HAM_SCRUB_DED_HALT_EN
  // Remembers a DED in the current word so NEXT can park in HALT
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) ded_seen_q <= 1'b0;
    else          ded_seen_q <= ded_seen_d;
  end
`endif

  // Next-state, datapath updates and bank strobes
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    intv_d     = intv_q;
    word_d     = word_q;
    wb_d       = wb_q;
    sec_d      = sec_q;
    ded_d      = ded_q;
    ded_addr_d = ded_addr_q;
    ded_irq_d  = 1'b0;
    pass_d     = 1'b0;
    abort_d    = abort_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    enc_data   = '0;
`ifdef HAM_SCRUB_DED_HALT_EN
    ded_seen_d = ded_seen_q;
`endif

    if ((state_q == CHECK || state_q == DECIDE || state_q == WRITE) && func_hit)
      abort_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (i_scrub_en) begin
          intv_d  = i_interval;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (intv_q == '0) state_d = READ;
        else              intv_d  = INTV_W'(intv_q - 1'b1);
      end
      READ: begin
        if (!i_func_busy) begin
          mem_req = 1'b1;
          abort_d = 1'b0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        word_d  = i_mem_rdata;
        state_d = DECIDE;
      end
      DECIDE: begin
        if (i_dec_ded) begin
          ded_d      = (ded_q == '1) ? ded_q : CNT_W'(ded_q + 1'b1);
          ded_irq_d  = 1'b1;
          ded_addr_d = addr_q;
          state_d    = NEXT;
`ifdef HAM_SCRUB_DED_HALT_EN
          ded_seen_d = 1'b1;
`endif
        end else if (i_dec_sec) begin
          sec_d    = (sec_q == '1) ? sec_q : CNT_W'(sec_q + 1'b1);
          enc_data = i_dec_data;
          wb_d     = i_enc_word;
          state_d  = WRITE;
        end else begin
          state_d = NEXT;
        end
      end
      WRITE: begin
        // A functional write to this address makes the corrected copy stale
        if (abort_q) begin
          state_d = NEXT;
        end else if (!i_func_busy) begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (addr_q == LAST_ADDR) begin
          addr_d = '0;
          pass_d = 1'b1;
        end else begin
          addr_d = ADDR_W'(addr_q + 1'b1);
        end
        if (i_scrub_en) begin
          intv_d  = i_interval;
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
`ifdef HAM_SCRUB_DED_HALT_EN
        if (ded_seen_q) begin
          ded_seen_d = 1'b0;
          state_d    = HALT;
        end
`endif
      end
      HALT: begin
`ifdef HAM_SCRUB_DED_HALT_EN
        if (!i_scrub_en) state_d = IDLE;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are gated by reset so a pending writeback never leaks out
  assign o_mem_req   = mem_req & i_rst_n;
  assign o_mem_we    = mem_we & i_rst_n;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wb_q;
  assign o_dec_word  = word_q;
  assign o_enc_data  = enc_data;
  assign o_busy      = (state_q != IDLE);
  assign o_sec_cnt   = sec_q;
  assign o_ded_cnt   = ded_q;
  assign o_ded_irq   = ded_irq_q;
  assign o_ded_addr  = ded_addr_q;
  assign o_pass_done = pass_q;

endmodule
